// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package serial_adder_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int MAX_WIDTH     = 32;

  // Encoding 2'd3 is never entered; the controller treats it as IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between the register front end and the sequencer.
interface serial_adder_ctrl_if
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// The team's 1-bit full adder cell, reused as the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic out,
  output logic cout
);

  assign out  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through a
// single full_adder cell, one bit per clock, and presents sum/cout with a
// one-cycle done pulse. The previous result stays visible while running.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_q, c_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fa_sum;
  logic               fa_cout;

  full_adder u_full_adder (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .out  (fa_sum),
    .cout (fa_cout)
  );

  // State, shift registers, carry, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      c_q      <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      c_q      <= c_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic; the result is latched on the final RUN edge so that the
  // last sum bit (still leaving the adder) is included when DONE is entered.
  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    c_d      = c_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          sum_sh_d = '0;
          c_d      = bus.cin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        c_d      = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = sum_sh_d;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: a WIDTH=8 instance for the main
// scenarios and a WIDTH=1 instance for the exhaustive single-bit sweep.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst_n;

  int assertCount = 0;
  int failCount   = 0;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // One 8-bit operation with a single-cycle start; checks latency (edges after
  // the accepting edge), busy length, result hold during RUN and the result.
  task automatic applyStimulus(input string tag, input logic [7:0] aVal,
                               input logic [7:0] bVal, input logic cinVal,
                               input logic [7:0] expSum, input logic expCout);
    logic [7:0] prevSum;
    int         edges;
    int         busyCycles;
    bit         sumMoved;
    @(negedge clk);
    prevSum    = bus8.sum;
    bus8.a     = aVal;
    bus8.b     = bVal;
    bus8.cin   = cinVal;
    bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    edges      = 0;
    busyCycles = 0;
    sumMoved   = 1'b0;
    while (!bus8.done && edges < 40) begin
      if (bus8.busy) busyCycles++;
      if (bus8.sum !== prevSum) sumMoved = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (bus8.busy) busyCycles++;
    checkOutput({tag, "_done_seen"}, 64'(bus8.done), 64'd1);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd8);
    checkOutput({tag, "_busy_len"}, 64'(busyCycles), 64'd9);
    checkOutput({tag, "_sum_held_in_run"}, 64'(sumMoved), 64'd0);
    checkOutput({tag, "_sum"}, 64'(bus8.sum), 64'(expSum));
    checkOutput({tag, "_cout"}, 64'(bus8.cout), 64'(expCout));
    @(negedge clk);
    checkOutput({tag, "_done_one_cycle"}, 64'(bus8.done), 64'd0);
    checkOutput({tag, "_busy_after"}, 64'(bus8.busy), 64'd0);
    checkOutput({tag, "_sum_kept"}, 64'(bus8.sum), 64'(expSum));
  endtask

  // Main stimulus sequence.
  initial begin
    logic [8:0] expQ[$];
    logic [8:0] expVal;
    logic [7:0] gotSum;
    logic       gotCout;
    logic [1:0] exp1;
    int         doneCount;
    int         ops;
    int         cyc;
    int         prevDoneCyc;
    int         edges;

    // Reset held with random inputs, including start.
    rst_n      = 1'b0;
    bus8.start = 1'b1;
    bus8.a     = 8'($urandom);
    bus8.b     = 8'($urandom);
    bus8.cin   = 1'($urandom);
    bus1.start = 1'b1;
    bus1.a     = 1'($urandom);
    bus1.b     = 1'($urandom);
    bus1.cin   = 1'($urandom);
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(bus8.busy), 64'd0);
    checkOutput("reset_done", 64'(bus8.done), 64'd0);
    checkOutput("reset_sum", 64'(bus8.sum), 64'd0);
    checkOutput("reset_cout", 64'(bus8.cout), 64'd0);
    checkOutput("reset_w1_busy", 64'(bus1.busy), 64'd0);
    bus8.start = 1'b0;
    bus1.start = 1'b0;
    rst_n      = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("post_reset_busy", 64'(bus8.busy), 64'd0);
    checkOutput("post_reset_done", 64'(bus8.done), 64'd0);
    checkOutput("post_reset_sum", 64'(bus8.sum), 64'd0);

    // Basic and carry-chain operations.
    applyStimulus("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    applyStimulus("carry_ff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    applyStimulus("carry_ff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Start re-pulsed mid-RUN with a different operand must be ignored.
    @(negedge clk);
    bus8.a     = 8'h01;
    bus8.b     = 8'h01;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.a     = 8'h80;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    doneCount  = 0;
    gotSum     = 8'h00;
    gotCout    = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        doneCount++;
        gotSum  = bus8.sum;
        gotCout = bus8.cout;
      end
    end
    checkOutput("ignore_done_count", 64'(doneCount), 64'd1);
    checkOutput("ignore_sum", 64'(gotSum), 64'h02);
    checkOutput("ignore_cout", 64'(gotCout), 64'd0);

    // Reset dropped at the fourth RUN cycle aborts with no done.
    @(negedge clk);
    bus8.a     = 8'h0F;
    bus8.b     = 8'h01;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(bus8.busy), 64'd0);
    checkOutput("abort_done", 64'(bus8.done), 64'd0);
    checkOutput("abort_sum", 64'(bus8.sum), 64'd0);
    checkOutput("abort_cout", 64'(bus8.cout), 64'd0);
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus8.done) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'd0);
    applyStimulus("after_abort", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // WIDTH=1 exhaustive: one RUN cycle, {cout,sum} = a+b+cin.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      bus1.a     = 1'(v >> 2);
      bus1.b     = 1'(v >> 1);
      bus1.cin   = 1'(v);
      bus1.start = 1'b1;
      exp1       = 2'(v >> 2 & 1) + 2'(v >> 1 & 1) + 2'(v & 1);
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      edges      = 0;
      while (!bus1.done && edges < 10) begin
        @(posedge clk);
        edges++;
        @(negedge clk);
      end
      checkOutput($sformatf("w1_latency_%0d", v), 64'(edges), 64'd1);
      checkOutput($sformatf("w1_result_%0d", v), 64'({bus1.cout, bus1.sum}),
                  64'(exp1));
    end

    // Back-to-back random operations with start held high.
    @(negedge clk);
    bus8.a     = 8'($urandom_range(0, 255));
    bus8.b     = 8'($urandom_range(0, 255));
    bus8.cin   = 1'($urandom_range(0, 1));
    bus8.start = 1'b1;
    if (!bus8.busy) expQ.push_back({1'b0, bus8.a} + {1'b0, bus8.b} + 9'(bus8.cin));
    ops         = 0;
    cyc         = 0;
    prevDoneCyc = -1;
    while (ops < 1000 && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      if (bus8.done) begin
        if (expQ.size() == 0) begin
          checkOutput("sweep_unexpected_done", 64'd1, 64'd0);
        end else begin
          expVal = expQ.pop_front();
          checkOutput("sweep_result", 64'({bus8.cout, bus8.sum}), 64'(expVal));
        end
        if (prevDoneCyc >= 0)
          checkOutput("sweep_period", 64'(cyc - prevDoneCyc), 64'd10);
        prevDoneCyc = cyc;
        ops++;
        if (ops == 1000) begin
          bus8.start = 1'b0;
          break;
        end
      end
      bus8.a   = 8'($urandom_range(0, 255));
      bus8.b   = 8'($urandom_range(0, 255));
      bus8.cin = 1'($urandom_range(0, 1));
      if (!bus8.busy) expQ.push_back({1'b0, bus8.a} + {1'b0, bus8.b} + 9'(bus8.cin));
    end
    bus8.start = 1'b0;
    checkOutput("sweep_ops", 64'(ops), 64'd1000);
    repeat (3) @(negedge clk);
    checkOutput("sweep_idle_busy", 64'(bus8.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assertCount, failCount);
    $finish;
  end

endmodule
